// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// an optional first-word-fall-through read port.
//
// Occupancy (level) is the single source of truth for full/empty. Every
// status flag is registered from the next-cycle level, so the flags are
// valid in the cycle after the edge that changed them.

module sync_fifo_flex #(
   parameter int DSIZE  = 8,
   parameter int ASIZE  = 4,
   parameter int AF_LVL = 12,
   parameter int AE_LVL = 2,
   parameter int FWFT   = 0
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             walmost_full,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int             DEPTH   = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LVL);
   localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LVL);
   localparam logic [ASIZE:0] LVL_ONE = (ASIZE+1)'(1'b1);
   localparam logic [ASIZE:0] LVL_ZERO = (ASIZE+1)'(1'b0);
   localparam logic [ASIZE-1:0] PTR_ONE  = ASIZE'(1'b1);
   localparam logic [ASIZE-1:0] PTR_ZERO = ASIZE'(1'b0);

   // Storage and state
   logic [DSIZE-1:0] mem_r [DEPTH];
   logic [ASIZE-1:0] wptr_r;
   logic [ASIZE-1:0] rptr_r;
   logic [ASIZE:0]   level_r;
   logic [DSIZE-1:0] rdata_r;
   logic             wfull_r;
   logic             rempty_r;
   logic             walmost_full_r;
   logic             ralmost_empty_r;
   logic             overflow_r;
   logic             underflow_r;

   // Next-state helpers
   logic             we_s;
   logic             re_s;
   logic [ASIZE:0]   level_nxt_s;
   logic [ASIZE-1:0] wptr_nxt_s;
   logic [ASIZE-1:0] rptr_nxt_s;
   logic [DSIZE-1:0] head_s;
   logic             overflow_nxt_s;
   logic             underflow_nxt_s;

   // Accept/reject decisions, next occupancy, next pointers and FWFT head word
   always_comb begin
      we_s            = winc && !wfull_r;
      re_s            = rinc && !rempty_r;
      level_nxt_s     = level_r;
      wptr_nxt_s      = wptr_r;
      rptr_nxt_s      = rptr_r;
      head_s          = mem_r[rptr_r];
      overflow_nxt_s  = overflow_r;
      underflow_nxt_s = underflow_r;

      if (we_s && !re_s) begin
         level_nxt_s = level_r + LVL_ONE;
      end else if (re_s && !we_s) begin
         level_nxt_s = level_r - LVL_ONE;
      end else begin
         level_nxt_s = level_r;
      end

      if (we_s) begin
         wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
         wptr_nxt_s = wptr_r;
      end

      if (re_s) begin
         rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
         rptr_nxt_s = rptr_r;
      end

      // When the write lands exactly on the next head slot, no older word
      // remains, so the head must come straight from wdata (memory is not
      // yet written at this edge).
      if (we_s && (wptr_r == rptr_nxt_s)) begin
         head_s = wdata;
      end else begin
         head_s = mem_r[rptr_nxt_s];
      end

      // A new error at the same edge as clr_err wins over the clear.
      if (winc && wfull_r) begin
         overflow_nxt_s = 1'b1;
      end else if (clr_err) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end

      if (rinc && rempty_r) begin
         underflow_nxt_s = 1'b1;
      end else if (clr_err) begin
         underflow_nxt_s = 1'b0;
      end else begin
         underflow_nxt_s = underflow_r;
      end
   end

   // Storage array write; contents are intentionally not reset
   always_ff @(posedge wclk) begin
      if (we_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointers, occupancy and registered status flags
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr_r          <= PTR_ZERO;
         rptr_r          <= PTR_ZERO;
         level_r         <= LVL_ZERO;
         wfull_r         <= 1'b0;
         rempty_r        <= 1'b1;
         walmost_full_r  <= 1'b0;
         ralmost_empty_r <= 1'b1;
         overflow_r      <= 1'b0;
         underflow_r     <= 1'b0;
      end else begin
         wptr_r          <= wptr_nxt_s;
         rptr_r          <= rptr_nxt_s;
         level_r         <= level_nxt_s;
         wfull_r         <= (level_nxt_s == DEPTH_C);
         rempty_r        <= (level_nxt_s == LVL_ZERO);
         walmost_full_r  <= (level_nxt_s >= AF_C);
         ralmost_empty_r <= (level_nxt_s <= AE_C);
         overflow_r      <= overflow_nxt_s;
         underflow_r     <= underflow_nxt_s;
      end
   end

   // Read data register: popped word (standard) or upcoming head word (FWFT)
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         rdata_r <= {DSIZE{1'b0}};
      end else if (FWFT != 0) begin
         if (level_nxt_s != LVL_ZERO) begin
            rdata_r <= head_s;
         end
      end else if (re_s) begin
         rdata_r <= mem_r[rptr_r];
      end
   end

   assign wfull         = wfull_r;
   assign rempty        = rempty_r;
   assign walmost_full  = walmost_full_r;
   assign ralmost_empty = ralmost_empty_r;
   assign level         = level_r;
   assign rdata         = rdata_r;
   assign overflow      = overflow_r;
   assign underflow     = underflow_r;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode instance checked by a
// cycle-level occupancy/flag model and a read-data scoreboard, plus an
// FWFT instance exercised with directed checks.

module tb_sync_fifo_flex;

   logic wclk = 1'b0;
   logic wrst_n = 1'b0;

   always #5 wclk = ~wclk;

   // Standard-mode instance signals
   logic       a_winc = 1'b0, a_rinc = 1'b0, a_clr = 1'b0;
   logic [7:0] a_wdata = 8'h00;
   logic       a_wfull, a_waf, a_rempty, a_rae, a_ovf, a_unf;
   logic [7:0] a_rdata;
   logic [4:0] a_level;

   // FWFT instance signals
   logic       b_winc = 1'b0, b_rinc = 1'b0, b_clr = 1'b0;
   logic [7:0] b_wdata = 8'h00;
   logic       b_wfull, b_waf, b_rempty, b_rae, b_ovf, b_unf;
   logic [7:0] b_rdata;
   logic [4:0] b_level;

   sync_fifo_flex #(.DSIZE(8), .ASIZE(4), .AF_LVL(12), .AE_LVL(2), .FWFT(0)) dut_std (
      .wclk(wclk), .wrst_n(wrst_n), .winc(a_winc), .wdata(a_wdata),
      .wfull(a_wfull), .walmost_full(a_waf), .rinc(a_rinc), .rdata(a_rdata),
      .rempty(a_rempty), .ralmost_empty(a_rae), .level(a_level),
      .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
   );

   sync_fifo_flex #(.DSIZE(8), .ASIZE(4), .AF_LVL(12), .AE_LVL(2), .FWFT(1)) dut_fwft (
      .wclk(wclk), .wrst_n(wrst_n), .winc(b_winc), .wdata(b_wdata),
      .wfull(b_wfull), .walmost_full(b_waf), .rinc(b_rinc), .rdata(b_rdata),
      .rempty(b_rempty), .ralmost_empty(b_rae), .level(b_level),
      .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard of expected standard-mode read data (pushed by stimulus)
   logic [7:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model of occupancy and sticky errors for the standard instance
   int   mdl_lvl = 0;
   logic mdl_ovf = 1'b0, mdl_unf = 1'b0, rd_pend = 1'b0;
   logic we_m, re_m;
   assign we_m = a_winc && (mdl_lvl != 16);
   assign re_m = a_rinc && (mdl_lvl != 0);

   always @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         mdl_lvl <= 0;
         mdl_ovf <= 1'b0;
         mdl_unf <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         mdl_lvl <= mdl_lvl + (we_m ? 1 : 0) - (re_m ? 1 : 0);
         mdl_ovf <= (a_winc && mdl_lvl == 16) ? 1'b1 : (a_clr ? 1'b0 : mdl_ovf);
         mdl_unf <= (a_rinc && mdl_lvl == 0)  ? 1'b1 : (a_clr ? 1'b0 : mdl_unf);
         rd_pend <= re_m;
      end
   end

   logic [10:0] exp_f, act_f;
   assign exp_f = {5'(mdl_lvl), (mdl_lvl == 16), (mdl_lvl >= 12), (mdl_lvl == 0),
                   (mdl_lvl <= 2), mdl_ovf, mdl_unf};
   assign act_f = {a_level, a_wfull, a_waf, a_rempty, a_rae, a_ovf, a_unf};

   // Monitor: flags every cycle, read data whenever a read was accepted
   always @(negedge wclk) begin
      check("flags{lvl,full,afull,empty,aempty,ovf,unf}", {21'd0, act_f}, {21'd0, exp_f});
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            check("rdata_unexpected_read", 32'd1, 32'd0);
         end else begin
            check("rdata", {24'd0, a_rdata}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      a_winc  = w;
      a_wdata = d;
      a_rinc  = r;
      a_clr   = c;
      @(posedge wclk);
      #1;
   endtask

   task automatic bstep(input logic w, input logic [7:0] d, input logic r);
      b_winc  = w;
      b_wdata = d;
      b_rinc  = r;
      @(posedge wclk);
      #1;
      b_winc = 1'b0;
      b_rinc = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge wclk);
      #1;
      check("reset_rdata", {24'd0, a_rdata}, 32'd0);
      check("reset_level", {27'd0, a_level}, 32'd0);
      wrst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Fill 0x00..0x0F, then overflow attempt with 0xAA
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      check("ovf_level", {27'd0, a_level}, 32'd16);
      check("ovf_flag", {31'd0, a_ovf}, 32'd1);
      // Drain: 0x00..0x0F in order, 0xAA must never appear
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_empty", {31'd0, a_rempty}, 32'd1);

      // Underflow, clear, then read+clear together (set wins)
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("unf_set", {31'd0, a_unf}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("unf_clr", {31'd0, a_unf}, 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("unf_set_wins", {31'd0, a_unf}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Level 5, then 40 simultaneous read/write cycles across pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         exp_q.push_back(8'h10 + 8'(k));
         step(1'b1, 8'h15 + 8'(k), 1'b1, 1'b0);
      end
      check("simul_level", {27'd0, a_level}, 32'd5);
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(8'h38 + 8'(k));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Full with simultaneous read and write: read wins, write dropped
      for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h40);
      step(1'b1, 8'hEE, 1'b1, 1'b0);
      check("full_simul_level", {27'd0, a_level}, 32'd15);
      check("full_simul_ovf", {31'd0, a_ovf}, 32'd1);
      for (int i = 0; i < 15; i++) begin
         exp_q.push_back(8'h41 + 8'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset mid-operation at level 9
      for (int i = 0; i < 9; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("pre_rst_level", {27'd0, a_level}, 32'd9);
      #3;
      wrst_n = 1'b0;
      #1;
      check("midrst_level", {27'd0, a_level}, 32'd0);
      check("midrst_rempty", {31'd0, a_rempty}, 32'd1);
      check("midrst_raempty", {31'd0, a_rae}, 32'd1);
      check("midrst_rdata", {24'd0, a_rdata}, 32'd0);
      exp_q.delete();
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(8'h99);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("post_rst_rdata", {24'd0, a_rdata}, 32'h99);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      // FWFT instance
      check("fwft_reset_empty", {31'd0, b_rempty}, 32'd1);
      bstep(1'b1, 8'h5C, 1'b0);
      check("fwft_first_rempty", {31'd0, b_rempty}, 32'd0);
      check("fwft_first_rdata", {24'd0, b_rdata}, 32'h5C);
      bstep(1'b0, 8'h00, 1'b0);
      check("fwft_hold_rdata", {24'd0, b_rdata}, 32'h5C);
      bstep(1'b0, 8'h00, 1'b1);
      check("fwft_pop_rempty", {31'd0, b_rempty}, 32'd1);
      check("fwft_pop_level", {27'd0, b_level}, 32'd0);
      bstep(1'b1, 8'h31, 1'b0);
      bstep(1'b1, 8'h32, 1'b0);
      check("fwft_head_31", {24'd0, b_rdata}, 32'h31);
      check("fwft_level2", {27'd0, b_level}, 32'd2);
      bstep(1'b0, 8'h00, 1'b1);
      check("fwft_next_32", {24'd0, b_rdata}, 32'h32);
      check("fwft_next_rempty", {31'd0, b_rempty}, 32'd0);
      bstep(1'b1, 8'h33, 1'b1);
      check("fwft_simul_33", {24'd0, b_rdata}, 32'h33);
      check("fwft_simul_level", {27'd0, b_level}, 32'd1);
      bstep(1'b0, 8'h00, 1'b1);
      check("fwft_drained", {31'd0, b_rempty}, 32'd1);
      bstep(1'b0, 8'h00, 1'b1);
      check("fwft_underflow", {31'd0, b_unf}, 32'd1);

      repeat (2) @(posedge wclk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
